// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// uart_rx_cfg: oversampled UART receiver with configurable data,
// parity and stop bits, delivering words over a valid/ready output.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 enable_rx,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 sampling,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] r_data_q, r_data_d;
  logic                 r_valid_q, r_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sampling_q, sampling_d;

  logic          fall;
  logic          smp;
  logic [TW-1:0] limit;

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall    = prev_q & ~sync2_q;
    limit   = (state_q == S_START) ? HALF_M1 : FULL_M1;
    smp     = baud_tick && (state_q != S_IDLE) && (tick_q == limit);
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    sampling_d = smp;

    if (baud_tick && state_q != S_IDLE) begin
      tick_d = smp ? '0 : tick_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable_rx && fall) begin
          state_d = S_START;
          tick_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (smp) begin
          state_d = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (smp) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY == 0) ? S_STOP : S_PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (smp) begin
          perr_d  = (^shift_q) ^ sync2_q ^ ODD_PAR;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (smp) begin
          if (!sync2_q) begin
            ferr_d = 1'b1;
          end
          if (stop_q == LAST_STOP) begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts any partial frame, including its final sample.
    if (!enable_rx) begin
      state_d    = S_IDLE;
      tick_d     = '0;
      bit_d      = '0;
      stop_d     = 1'b0;
      done_d     = 1'b0;
      sampling_d = 1'b0;
    end
  end

  always_comb begin
    r_data_d     = r_data_q;
    r_valid_d    = r_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (done_q) begin
      r_data_d     = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q;
      r_valid_d    = 1'b1;
      overrun_d    = r_valid_q & ~r_ready;
    end else if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      tick_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sampling_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      r_data_q     <= r_data_d;
      r_valid_q    <= r_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      sampling_q   <= sampling_d;
    end
  end

  assign r_data     = r_data_q;
  assign r_valid    = r_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign sampling   = sampling_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// tb_uart_rx_cfg: scoreboard bench for an 8N1 and an 8E2 receiver
// sharing clock, ticks, enable, reset and consumer ready.
module tb_uart_rx_cfg;

  localparam int OS = 16;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       enable_rx = 1'b1;
  logic       r_ready = 1'b1;
  logic       rxd [2] = '{1'b1, 1'b1};
  logic [7:0] r_data [2];
  logic       r_valid [2];
  logic       parity_err [2];
  logic       frame_err [2];
  logic       overrun [2];
  logic       sampling [2];
  logic       busy [2];

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   samp_cnt [2] = '{0, 0};
  int   ovr_cnt [2] = '{0, 0};
  logic prev_valid [2] = '{1'b0, 1'b0};
  logic prev_samp [2] = '{1'b0, 1'b0};
  int   rdy_mode = 1;

  uart_rx_cfg #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .enable_rx(enable_rx), .rxd(rxd[0]),
    .r_data(r_data[0]), .r_valid(r_valid[0]), .r_ready(r_ready),
    .parity_err(parity_err[0]), .frame_err(frame_err[0]),
    .overrun(overrun[0]), .sampling(sampling[0]), .busy(busy[0])
  );

  uart_rx_cfg #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .enable_rx(enable_rx), .rxd(rxd[1]),
    .r_data(r_data[1]), .r_valid(r_valid[1]), .r_ready(r_ready),
    .parity_err(parity_err[1]), .frame_err(frame_err[1]),
    .overrun(overrun[1]), .sampling(sampling[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    baud_tick = ($urandom_range(0, 2) == 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 2) r_ready = 1'($urandom_range(0, 1));
    else r_ready = (rdy_mode == 1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input int k, input logic v, input int nt);
    #1;
    rxd[k] = v;
    wait_ticks(nt);
  endtask

  // One complete frame plus one idle bit; optionally announces the word.
  task automatic send_frame(input int k, input logic [7:0] d,
                            input logic flip, input logic [1:0] bad,
                            input logic expect_word);
    exp_t e;
    int   ns;
    int   s0;
    logic pb;
    ns = (k == 0) ? 1 : 2;
    s0 = samp_cnt[k];
    e.inst = k;
    e.data = d;
    e.perr = (k == 1) && flip;
    e.ferr = bad[0] || (ns == 2 && bad[1]);
    if (expect_word) exp_q.push_back(e);
    drive_bit(k, 1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i], OS);
    if (k == 1) begin
      pb = (^d) ^ flip;
      drive_bit(k, pb, OS);
    end
    for (int s = 0; s < ns; s++) drive_bit(k, ~bad[s], OS);
    drive_bit(k, 1'b1, OS);
    chk($sformatf("samples_%0d", k), samp_cnt[k] - s0, 1 + 8 + k + ns);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sampling[k]) samp_cnt[k]++;
        if (overrun[k]) ovr_cnt[k]++;
        if (rst_n && r_valid[k] && !prev_valid[k])
          chk($sformatf("load_latency_%0d", k), int'(prev_samp[k]), 1);
        if (r_valid[k] && r_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_word_%0d", k), exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("word_inst", k, e.inst);
            chk($sformatf("r_data_%0d", k), int'(r_data[k]), int'(e.data));
            chk($sformatf("parity_err_%0d", k), int'(parity_err[k]),
                int'(e.perr));
            chk($sformatf("frame_err_%0d", k), int'(frame_err[k]),
                int'(e.ferr));
          end
        end
        prev_valid[k] = r_valid[k];
        prev_samp[k] = sampling[k];
      end
    end
  endtask

  task automatic run_tests();
    int s0;
    int o0;
    int k;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_r_data_%0d", i), int'(r_data[i]), 0);
      chk($sformatf("rst_r_valid_%0d", i), int'(r_valid[i]), 0);
      chk($sformatf("rst_parity_%0d", i), int'(parity_err[i]), 0);
      chk($sformatf("rst_frame_%0d", i), int'(frame_err[i]), 0);
      chk($sformatf("rst_overrun_%0d", i), int'(overrun[i]), 0);
      chk($sformatf("rst_sampling_%0d", i), int'(sampling[i]), 0);
      chk($sformatf("rst_busy_%0d", i), int'(busy[i]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(4);

    send_frame(0, 8'hA5, 1'b0, 2'b00, 1'b1);
    drain();

    send_frame(1, 8'h07, 1'b1, 2'b00, 1'b1);
    send_frame(1, 8'h07, 1'b0, 2'b00, 1'b1);
    drain();

    send_frame(0, 8'h3C, 1'b0, 2'b01, 1'b1);
    send_frame(0, 8'h55, 1'b0, 2'b00, 1'b1);
    send_frame(1, 8'h96, 1'b0, 2'b10, 1'b1);
    drain();

    // Glitch shorter than half a bit.
    s0 = samp_cnt[0];
    drive_bit(0, 1'b0, OS / 4);
    drive_bit(0, 1'b1, 2 * OS);
    chk("false_start_samples", samp_cnt[0] - s0, 1);
    chk("false_start_busy", int'(busy[0]), 0);
    chk("false_start_valid", int'(r_valid[0]), 0);

    rdy_mode = 0;
    o0 = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 2'b00, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("overrun_pulses", ovr_cnt[0] - o0, 1);
    chk("overrun_valid", int'(r_valid[0]), 1);
    chk("overrun_data", int'(r_data[0]), 'h22);
    rdy_mode = 1;
    while (!r_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("valid_clear", int'(r_valid[0]), 0);
    drain();

    // 0xFF aborted by enable during bit 4.
    drive_bit(0, 1'b0, OS);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, OS);
    drive_bit(0, 1'b1, OS / 2);
    #1 enable_rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("disable_busy", int'(busy[0]), 0);
    wait_ticks(2);
    #1 enable_rx = 1'b1;
    wait_ticks(5 * OS);
    chk("disable_valid", int'(r_valid[0]), 0);

    // Second frame cut short by reset.
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0, OS);
    chk("midframe_busy", int'(busy[0]), 1);
    #1;
    rst_n = 1'b0;
    rxd[0] = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_valid", int'(r_valid[0]), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(2 * OS);
    chk("post_reset_busy", int'(busy[0]), 0);
    send_frame(0, 8'h81, 1'b0, 2'b00, 1'b1);
    drain();

    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 1));
      send_frame(k, 8'($urandom),
                 ($urandom_range(0, 3) == 0),
                 {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
                 1'b1);
      if ($urandom_range(0, 1) == 1) wait_ticks($urandom_range(1, 20));
    end
    drain();
    chk("overrun_total_b", ovr_cnt[1], 0);
  endtask

  initial begin
    fork
      monitor();
      begin
        run_tests();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period, even, legal range 8..32.
REQ-003 Parameter PARITY, default 0, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 baud_tick  in  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate.
REQ-008 enable_rx  in  1  receiver enable; low forces IDLE.
REQ-009 rxd  in  1  asynchronous serial input, idle high, LSB first.
REQ-010 r_data  out  DATA_BITS  received word, valid while r_valid=1.
REQ-011 r_valid  out  1  word available; held until accepted.
REQ-012 r_ready  in  1  consumer accepts word when r_valid & r_ready on a clk edge.
REQ-013 parity_err  out  1  parity mismatch flag for the word in r_data; 0 when PARITY=0.
REQ-014 frame_err  out  1  a stop bit sampled 0 for the word in r_data.
REQ-015 overrun  out  1  one-clk pulse: a new word completed while r_valid=1.
REQ-016 sampling  out  1  one-clk pulse on every bit-centre sample (start, data, parity, stop).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 rxd SHALL pass a 2-flop synchroniser (reset value 1) before any use; edge detection uses the synchronised value and its 1-cycle delay.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-020 IDLE -> START on a synchronised 1->0 transition while enable_rx=1; tick counter cleared.
REQ-021 START: after OVERSAMPLE/2 baud_ticks, sample; sample=1 -> IDLE (false start, no output, no flags); sample=0 -> DATA.
REQ-022 DATA/PARITY/STOP: each bit sampled after OVERSAMPLE baud_ticks from the previous sample; DATA shifts LSB first, DATA_BITS samples, bit counter wraps to 0 on exit.
REQ-023 PARITY: error when XOR(data bits, parity bit) = 1 for even mode, = 0 for odd mode.
REQ-024 STOP: STOP_BITS samples; any 0 sample sets the frame error for this word; the frame always completes (no early exit).
REQ-025 Frame completion: on the clk edge of the last stop sample, state -> IDLE; on the next edge r_data, parity_err, frame_err load together and r_valid=1 (latency 1 clk from last sample).
REQ-026 r_valid SHALL clear on the edge where r_valid & r_ready=1, unless a new word loads on that same edge, in which case it stays 1 with the new word and no overrun.
REQ-027 Completion with r_valid=1 and r_ready=0: new word overwrites r_data/flags, r_valid stays 1, overrun pulses 1 clk.
REQ-028 enable_rx=0 at any point: state -> IDLE within 1 clk, partial frame discarded; r_data/r_valid/flags unchanged.
REQ-029 A falling edge that occurs while not in IDLE SHALL be ignored; a new start is detectable in the first IDLE cycle after a frame.
REQ-030 baud_tick=0 SHALL freeze all counters; no sample occurs without a baud_tick.

Reset
REQ-031 rst_n=0 asynchronously: state IDLE, counters 0, shift register 0, synchroniser flops 1; r_data=0, r_valid=0, parity_err=0, frame_err=0, overrun=0, sampling=0, busy=0.
REQ-032 Deassertion of rst_n mid-frame SHALL leave the block in IDLE, waiting for a fresh falling edge.

Verification
REQ-033 Defaults, frame 0xA5, stop=1, r_ready=1 -> r_data=0xA5, r_valid 1 clk, no flags, 10 sampling pulses.
REQ-034 PARITY=1, frame 0x07 with parity bit 0 -> r_data=0x07, parity_err=1; parity bit 1 -> parity_err=0.
REQ-035 Frame 0x3C with stop bit 0 -> r_data=0x3C, frame_err=1; next good frame 0x55 -> frame_err=0.
REQ-036 rxd low for OVERSAMPLE/4 ticks then high -> return to IDLE, r_valid stays 0, 1 sampling pulse.
REQ-037 r_ready=0, frames 0x11 then 0x22 -> r_data=0x22, r_valid=1, overrun one pulse; then r_ready=1 -> r_valid=0 next clk.
REQ-038 enable_rx=0 during data bit 4 of 0xFF, then rst_n pulse mid-frame of a second frame -> no output, busy=0, next clean frame 0x81 received correctly.
